// File: rtl/sha2_pkg.sv
// SHA-2 shared constants, state encoding and 32-bit round/schedule functions.
package sha2_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_ROUND,
    S_FINAL
  } state_t;

  localparam int SHA256_ROUNDS = 64;
  localparam int WORD_W        = 32;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] SHA224_IV = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Word i of a 256-bit chaining value, word 0 in the top bits.
  function automatic word_t iv_word(input logic [255:0] v, input int i);
    return v[255-32*i -: 32];
  endfunction

endpackage

// File: rtl/sha256_Krom.sv
// SHA-256 round-constant ROM; K[addr] registered, one cycle read latency.
// No flow control: a new address is accepted every cycle.
module sha256_Krom (
  input  logic        clk,
  input  logic [5:0]  addr,
  output logic [31:0] k
);

  localparam logic [31:0] KTAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  always_ff @(posedge clk) begin
    k <= KTAB[addr];
  end

endmodule

// File: rtl/sha256_wsched.sv
// SHA-256 message schedule: 16-word shift register, wt = W_t combinationally from slot 0.
// No flow control: load wins over advance; advance once per round.
module sha256_wsched
  import sha2_pkg::*;
(
  input  logic         clk,
  input  logic         load,
  input  logic         advance,
  input  logic [511:0] block,
  output word_t        wt
);

  word_t w [16];
  word_t w_new;

  // Slot j holds W_(t+j); the incoming word is W_(t+16).
  always_comb begin
    w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) begin
        w[i] <= block[511-32*i -: 32];
      end
    end else if (advance) begin
      for (int i = 0; i < 15; i++) begin
        w[i] <= w[i+1];
      end
      w[15] <= w_new;
    end
  end

  assign wt = w[0];

endmodule

// File: rtl/sha256_core.sv
// SHA-256 compression of one 512-bit block; accept at T, out_valid pulse at T+67 (SHA256_CORE_SHA224_EN adds mode224).
// in_ready is low while busy; in_valid during that time is ignored.
module sha256_core
  import sha2_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
`ifdef SHA256_CORE_SHA224_EN
  input  logic         mode224,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block,
  output logic         out_valid,
  output logic [255:0] digest
);

  state_t       state;
  logic [5:0]   round_idx;
  logic [5:0]   rom_addr;
  word_t        kt;
  word_t        wt;
  word_t        v  [8];
  word_t        hv [8];
  word_t        t1;
  word_t        t2;
  logic [255:0] iv_sel;
  logic [255:0] digest_nxt;
  logic         accept;

`ifdef SHA256_CORE_SHA224_EN
  logic         m224;

  always_comb begin
    iv_sel = mode224 ? SHA224_IV : SHA256_IV;
  end
`else
  always_comb begin
    iv_sel = SHA256_IV;
  end
`endif

  assign accept = (state == S_IDLE) && in_valid;

  // Address runs one round ahead to hide the ROM register; wraps on the last round.
  always_comb begin
    rom_addr = (state == S_ROUND) ? round_idx + 6'd1 : 6'd0;
  end

  sha256_Krom u_krom (
    .clk  (clk),
    .addr (rom_addr),
    .k    (kt)
  );

  sha256_wsched u_wsched (
    .clk     (clk),
    .load    (accept),
    .advance (state == S_ROUND),
    .block   (block),
    .wt      (wt)
  );

  always_comb begin
    t1 = v[7] + big_sigma1(v[4]) + ch(v[4], v[5], v[6]) + kt + wt;
    t2 = big_sigma0(v[0]) + maj(v[0], v[1], v[2]);
  end

  always_comb begin
    digest_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      digest_nxt[255-32*i -: 32] = hv[i] + v[i];
    end
`ifdef SHA256_CORE_SHA224_EN
    if (m224) begin
      digest_nxt[31:0] = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      digest    <= '0;
      round_idx <= '0;
      for (int i = 0; i < 8; i++) begin
        hv[i] <= iv_word(SHA256_IV, i);
        v[i]  <= '0;
      end
`ifdef SHA256_CORE_SHA224_EN
      m224      <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 8; i++) begin
              v[i] <= init ? iv_word(iv_sel, i) : hv[i];
              if (init) begin
                hv[i] <= iv_word(iv_sel, i);
              end
            end
`ifdef SHA256_CORE_SHA224_EN
            if (init) begin
              m224 <= mode224;
            end
`endif
            round_idx <= '0;
            in_ready  <= 1'b0;
            state     <= S_PRIME;
          end
        end
        S_PRIME: begin
          state <= S_ROUND;
        end
        S_ROUND: begin
          v[0] <= t1 + t2;
          v[1] <= v[0];
          v[2] <= v[1];
          v[3] <= v[2];
          v[4] <= v[3] + t1;
          v[5] <= v[4];
          v[6] <= v[5];
          v[7] <= v[6];
          round_idx <= round_idx + 6'd1;
          if (round_idx == 6'(SHA256_ROUNDS - 1)) begin
            state <= S_FINAL;
          end
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) begin
            hv[i] <= hv[i] + v[i];
          end
          digest    <= digest_nxt;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_core.sv
// Scoreboard bench for sha256_core: known-answer digests, handshake timing, mid-block reset.
module tb_sha256_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] block;
  logic         out_valid;
  logic [255:0] digest;
`ifdef SHA256_CORE_SHA224_EN
  logic         mode224;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_hs  = 0;
  logic [255:0] exp_q [$];
  int           hs_q  [$];

  localparam logic [511:0] ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] B1    = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] B2    = {{15{32'h0}}, 32'h000001c0};

  localparam logic [255:0] EXP_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EXP_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] EXP_H1    = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  localparam logic [255:0] EXP_2BLK  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`ifdef SHA256_CORE_SHA224_EN
  localparam logic [255:0] EXP_224   = {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0};
`endif

  sha256_core dut (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
`ifdef SHA256_CORE_SHA224_EN
    .mode224   (mode224),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .block     (block),
    .out_valid (out_valid),
    .digest    (digest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Observes handshakes and output pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        hs_q.push_back(cyc);
        n_hs++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 256'(exp_q.size() + 1), 256'(0));
        end else begin
          check("digest", digest, exp_q.pop_front());
          if (hs_q.size() > 0) begin
            check("latency", 256'(cyc - hs_q.pop_front()), 256'(67));
          end
        end
      end
    end
  end

  // Holds in_valid until accepted; t_acc is the cycle in which the handshake happened.
  task automatic send(input logic [511:0] blk, input logic ini, input logic [255:0] ex,
                      input bit expect_out, output int t_acc);
    bit acc;
    acc   = 1'b0;
    t_acc = -1;
    if (expect_out) exp_q.push_back(ex);
    block    = blk;
    init     = ini;
    in_valid = 1'b1;
    for (int b = 0; b < 300 && !acc; b++) begin
      acc   = in_ready;
      t_acc = cyc;
      @(posedge clk);
      #1;
    end
    check("accept_timeout", 256'(acc), 256'(1));
  endtask

  task automatic drain(input string tag);
    for (int b = 0; b < 200 && exp_q.size() != 0; b++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 256'(exp_q.size()), 256'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hs_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t1, t2, bad_rdy, bad_ov, hs0;
    rst      = 1'b1;
    init     = 1'b0;
    in_valid = 1'b0;
    block    = '0;
`ifdef SHA256_CORE_SHA224_EN
    mode224  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_digest", digest, '0);
    rst = 1'b0;

    // "abc" with busy-window checks and ignored in_valid pulses
    hs0 = n_hs;
    send(ABC, 1'b1, EXP_ABC, 1'b1, t1);
    in_valid = 1'b0;
    bad_rdy  = 0;
    bad_ov   = 0;
    for (int i = 1; i <= 66; i++) begin
      bad_rdy += int'(in_ready);
      bad_ov  += int'(out_valid);
      in_valid = (i % 20 == 5);
      block    = ~ABC;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("busy_in_ready", 256'(bad_rdy), 256'(0));
    check("busy_out_valid", 256'(bad_ov), 256'(0));
    check("t67_in_ready", 256'(in_ready), 256'(1));
    check("t67_out_valid", 256'(out_valid), 256'(1));
    check("busy_accepts", 256'(n_hs - hs0), 256'(1));
    drain("abc_drain");
    repeat (5) @(posedge clk);
    #1;
    check("digest_hold", digest, EXP_ABC);
    check("out_valid_pulse", 256'(out_valid), 256'(0));

    send(EMPTY, 1'b1, EXP_EMPTY, 1'b1, t1);
    in_valid = 1'b0;
    drain("empty_drain");

    // Two-block message, in_valid held across both blocks
    send(B1, 1'b1, EXP_H1, 1'b1, t1);
    send(B2, 1'b0, EXP_2BLK, 1'b1, t2);
    in_valid = 1'b0;
    check("b2b_gap", 256'(t2 - t1), 256'(67));
    drain("two_block_drain");

    // Reset during round 30 aborts the block
    send(ABC, 1'b1, '0, 1'b0, t1);
    in_valid = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    pulse_reset();
    check("abort_in_ready", 256'(in_ready), 256'(1));
    check("abort_out_valid", 256'(out_valid), 256'(0));
    check("abort_digest", digest, '0);
    repeat (80) @(posedge clk);
    #1;
    check("abort_no_output", digest, '0);
    send(ABC, 1'b1, EXP_ABC, 1'b1, t1);
    in_valid = 1'b0;
    drain("post_abort_drain");

    // init=0 right after reset chains from the IV
    pulse_reset();
    send(ABC, 1'b0, EXP_ABC, 1'b1, t1);
    in_valid = 1'b0;
    drain("noinit_drain");

`ifdef SHA256_CORE_SHA224_EN
    mode224 = 1'b1;
    send(ABC, 1'b1, EXP_224, 1'b1, t1);
    in_valid = 1'b0;
    mode224  = 1'b0;
    drain("sha224_drain");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_core.md
Name: sha256_core

Overview:
- SHA-256 compression engine; the consumer of `sha256_Krom`.
- Accepts one 512-bit message block per handshake, runs 64 rounds, and produces the updated 256-bit chaining value/digest.
- Drives the round index into an internal `sha256_Krom` instance and consumes K one cycle later.
- Padding and message framing are the upstream packer's job; this block only compresses blocks.

Parameters:
- None. Round count (64) and word width (32) are fixed constants in the package.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- init  in  1  sampled at handshake: 1 = first block of a message (chain from IV), 0 = chain from previous H
- in_valid  in  1  block valid
- in_ready  out  1  core idle, can accept a block
- block  in  512  message block, big-endian, W0 = block[511:480]
- out_valid  out  1  one-cycle pulse, digest updated
- digest  out  256  H0..H7, H0 = digest[255:224]; holds value until next update

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, in_ready=1, out_valid=0, digest=0, H=IV.
  - Reset mid-operation aborts the block; no out_valid.
- States: IDLE -> PRIME -> ROUND -> FINAL -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (cycle T): latch block into the 16-word schedule; a..h = (init ? IV : H), and H is also reloaded from IV if init=1; round_idx=0.
  - Next state PRIME.
- PRIME (T+1): ROM address 0 presented; K0 valid at T+2. in_ready=0.
- ROUND (T+2..T+65), 64 cycles, round t at cycle T+2+t:
  - ROM address = t+1 (wraps to 0 on the last round; output ignored).
  - Schedule: W_t for t<16 from the latched block. Otherwise W_t = s1(W_t-2)+W_t-7+s0(W_t-15)+W_t-16, all mod 2^32, via a 16-entry shift register.
  - Standard SHA-256 round update of a..h; all adds mod 2^32.
- FINAL (T+66):
  - H_i <= H_i + a..h_i, mod 2^32.
  - digest <= new H.
  - out_valid asserted at T+67 for exactly one cycle; state returns to IDLE at T+67, so in_ready=1 at T+67.
- Back-to-back: a block may be accepted at T+67 (same cycle as out_valid), giving 67-cycle throughput per block.
- in_valid while busy is ignored; the block input is not sampled after the handshake, so upstream may change it.
- init=0 on the very first block after reset chains from IV, since reset loads H=IV.

Optional Feature:
- Macro: SHA256_CORE_SHA224_EN.
- With the macro:
  - Adds port mode224 (in, 1), sampled at the handshake when init=1.
  - mode224=1 selects the SHA-224 IV.
  - digest[31:0] is forced to 0 on output for that message; internal H7 is kept for chaining.
  - mode224 latched at an init handshake persists for subsequent init=0 blocks.
- Without the macro: no mode224 port; SHA-256 IV always.

Decomposition:
- Package `sha2_pkg`:
  - SHA256_IV and SHA224_IV constants
  - SHA256_ROUNDS=64
  - functions for Ch, Maj, Sigma0, Sigma1, sigma0, sigma1 (32-bit)
  - state enum typedef
- One sub-module: `sha256_wsched` (16-word shift register plus W expansion; load and advance controls).
- `sha256_Krom` is instantiated unmodified.

Test Plan:
- "abc" padded single block, init=1 -> digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty string padded block, init=1 -> digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (init=1 then init=0), held in_valid back-to-back:
  - final digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1
  - second handshake at exactly T+67.
- Latency/handshake:
  - handshake at T -> in_ready=0 on T+1..T+66, out_valid=1 only at T+67.
  - in_valid pulses while busy are not accepted.
- Reset asserted at round 30:
  - next cycle in_ready=1, out_valid=0, digest=0.
  - then "abc" with init=1 gives the correct digest.
- SHA256_CORE_SHA224_EN build, mode224=1, "abc" -> digest[255:32]=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, digest[31:0]=0.
